// File: rtl/qcv_data_ram.sv
// Single-ported word RAM terminating the core's req/gnt/rvalid data bus.
// One transaction at a time, byte-enabled stores, optional programmable grant delay.
module qcv_data_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned GNT_DELAY   = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o
);

  localparam int unsigned IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SizeBytes = 32'(DEPTH_WORDS * 4);
  localparam int unsigned CntW      = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(GNT_DELAY);

  typedef enum logic [1:0] {
    StIdle,
    StWaitGnt,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rerr_q, rerr_d;
  logic            gnt;

  logic [31:0]     mem_q [DEPTH_WORDS];

  // Wrap-around subtraction makes addresses below BASE_ADDR land far out of range.
  logic [31:0]     offset;
  logic            in_range;
  logic [IdxW-1:0] word_idx;

  assign offset   = data_addr_i - BASE_ADDR;
  assign in_range = offset < SizeBytes;
  assign word_idx = offset[IdxW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (data_req_i) begin
          if (GNT_DELAY == 0) begin
            gnt = 1'b1;
          end else begin
            cnt_d   = CntW'(1);
            state_d = StWaitGnt;
          end
        end
      end
      StWaitGnt: begin
        if (!data_req_i) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          gnt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        // Response cycle never grants, even with a request pending.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (gnt) begin
      cnt_d   = '0;
      state_d = data_we_i ? StIdle : StResp;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    if (gnt && !data_we_i) begin
      rdata_d = in_range ? mem_q[word_idx] : 32'h0;
      rerr_d  = !in_range;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (gnt && data_we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem_q[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = (state_q == StResp);
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = (gnt && data_we_i && !in_range) || (data_rvalid_o && rerr_q);

  a_no_gnt_with_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(data_gnt_o && data_rvalid_o));

endmodule

// File: tb/tb_qcv_data_ram.sv
// Directed bench for qcv_data_ram: one instance with same-cycle grant, one with GNT_DELAY=3.
module tb_qcv_data_ram;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic        req0, gnt0, rvalid0, err0, we0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  be0;
  logic        req3, gnt3, rvalid3, err3, we3;
  logic [31:0] addr3, wdata3, rdata3;
  logic [3:0]  be3;

  int n_checks = 0;
  int n_fail   = 0;

  qcv_data_ram #(.GNT_DELAY(0)) u_dut0 (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .data_req_i    (req0),
    .data_gnt_o    (gnt0),
    .data_rvalid_o (rvalid0),
    .data_err_o    (err0),
    .data_addr_i   (addr0),
    .data_we_i     (we0),
    .data_be_i     (be0),
    .data_wdata_i  (wdata0),
    .data_rdata_o  (rdata0)
  );

  qcv_data_ram #(.GNT_DELAY(3)) u_dut3 (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .data_req_i    (req3),
    .data_gnt_o    (gnt3),
    .data_rvalid_o (rvalid3),
    .data_err_o    (err3),
    .data_addr_i   (addr3),
    .data_we_i     (we3),
    .data_be_i     (be3),
    .data_wdata_i  (wdata3),
    .data_rdata_o  (rdata3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // All transaction tasks start and end mid-cycle, after the rising edge.
  task automatic store0(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                        input logic exp_err);
    req0 = 1'b1; we0 = 1'b1; addr0 = addr; be0 = be; wdata0 = wd;
    #1;
    check_eq("st0_gnt", 32'(gnt0), 32'd1);
    check_eq("st0_err", 32'(err0), 32'(exp_err));
    check_eq("st0_rvalid", 32'(rvalid0), 32'd0);
    @(posedge clk_i); #1;
    req0 = 1'b0; we0 = 1'b0; be0 = 4'h0;
    #1;
    check_eq("st0_post_rvalid", 32'(rvalid0), 32'd0);
    check_eq("st0_post_err", 32'(err0), 32'd0);
  endtask

  task automatic load0(input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err);
    req0 = 1'b1; we0 = 1'b0; addr0 = addr;
    #1;
    check_eq("ld0_gnt", 32'(gnt0), 32'd1);
    check_eq("ld0_gnt_rvalid", 32'(rvalid0), 32'd0);
    check_eq("ld0_gnt_err", 32'(err0), 32'd0);
    @(posedge clk_i); #1;
    req0 = 1'b0;
    #1;
    check_eq("ld0_rvalid", 32'(rvalid0), 32'd1);
    check_eq("ld0_rdata", rdata0, exp_data);
    check_eq("ld0_err", 32'(err0), 32'(exp_err));
    check_eq("ld0_resp_gnt", 32'(gnt0), 32'd0);
    @(posedge clk_i); #2;
    check_eq("ld0_rvalid_1cyc", 32'(rvalid0), 32'd0);
  endtask

  // Hold a request on the delayed instance for n cycles, each required to be ungranted.
  task automatic hold3(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input int n);
    req3 = 1'b1; we3 = we; addr3 = addr; be3 = be; wdata3 = wd;
    for (int i = 0; i < n; i++) begin
      #1;
      check_eq("d3_wait_nogrant", 32'(gnt3), 32'd0);
      @(posedge clk_i); #1;
    end
  endtask

  task automatic store3(input logic [31:0] addr, input logic [31:0] wd);
    hold3(1'b1, addr, 4'hF, wd, 3);
    #1;
    check_eq("d3_st_gnt", 32'(gnt3), 32'd1);
    check_eq("d3_st_err", 32'(err3), 32'd0);
    @(posedge clk_i); #1;
    req3 = 1'b0; we3 = 1'b0;
    #1;
    check_eq("d3_st_post_gnt", 32'(gnt3), 32'd0);
  endtask

  task automatic load3(input logic [31:0] addr, input logic [31:0] exp_data);
    hold3(1'b0, addr, 4'h0, 32'h0, 3);
    #1;
    check_eq("d3_ld_gnt", 32'(gnt3), 32'd1);
    @(posedge clk_i); #1;
    req3 = 1'b0;
    #1;
    check_eq("d3_ld_rvalid", 32'(rvalid3), 32'd1);
    check_eq("d3_ld_rdata", rdata3, exp_data);
    @(posedge clk_i); #2;
  endtask

  initial begin
    rst_ni = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = '0; wdata0 = '0;
    req3 = 1'b0; we3 = 1'b0; addr3 = '0; be3 = '0; wdata3 = '0;
    #1;
    check_eq("rst_gnt0", 32'(gnt0), 32'd0);
    check_eq("rst_rvalid0", 32'(rvalid0), 32'd0);
    check_eq("rst_err0", 32'(err0), 32'd0);
    check_eq("rst_rdata0", rdata0, 32'h0);
    check_eq("rst_rvalid3", 32'(rvalid3), 32'd0);
    check_eq("rst_rdata3", rdata3, 32'h0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Basic store then load, including read-after-write in the next cycle
    store0(32'h0001_0010, 4'hF, 32'hDEAD_BEEF, 1'b0);
    load0(32'h0001_0010, 32'hDEAD_BEEF, 1'b0);

    // Byte-enable merge
    store0(32'h0001_0020, 4'hF, 32'h1122_3344, 1'b0);
    store0(32'h0001_0020, 4'b1000, 32'hAA00_0000, 1'b0);
    load0(32'h0001_0020, 32'hAA22_3344, 1'b0);

    // be=0 is a no-op
    store0(32'h0001_0010, 4'h0, 32'h0000_0000, 1'b0);
    load0(32'h0001_0010, 32'hDEAD_BEEF, 1'b0);

    // Stores leave rdata untouched
    store0(32'h0001_0FFC, 4'hF, 32'h5A5A_5A5A, 1'b0);
    check_eq("rdata_hold", rdata0, 32'hDEAD_BEEF);
    store0(32'h0001_0000, 4'hF, 32'hC0FF_EE11, 1'b0);

    // Out of range: below base aliases the last word index, above end aliases word 0
    store0(32'h0000_FFFC, 4'hF, 32'hFFFF_FFFF, 1'b1);
    load0(32'h0001_0FFC, 32'h5A5A_5A5A, 1'b0);
    load0(32'h0001_1000, 32'h0000_0000, 1'b1);
    load0(32'h0001_0000, 32'hC0FF_EE11, 1'b0);

    // Back-to-back loads with req held through the response cycle
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0001_0010;
    #1;
    check_eq("b2b_gnt_a", 32'(gnt0), 32'd1);
    check_eq("b2b_rvalid_a", 32'(rvalid0), 32'd0);
    @(posedge clk_i); #1;
    addr0 = 32'h0001_0020;
    #1;
    check_eq("b2b_resp_gnt", 32'(gnt0), 32'd0);
    check_eq("b2b_resp_rvalid", 32'(rvalid0), 32'd1);
    check_eq("b2b_resp_rdata", rdata0, 32'hDEAD_BEEF);
    @(posedge clk_i); #2;
    check_eq("b2b_gnt_b", 32'(gnt0), 32'd1);
    check_eq("b2b_rvalid_b", 32'(rvalid0), 32'd0);
    @(posedge clk_i); #1;
    req0 = 1'b0;
    #1;
    check_eq("b2b_resp2_rvalid", 32'(rvalid0), 32'd1);
    check_eq("b2b_resp2_rdata", rdata0, 32'hAA22_3344);
    check_eq("b2b_resp2_gnt", 32'(gnt0), 32'd0);
    @(posedge clk_i); #2;

    // Delayed grant: granted in the 4th held cycle
    store3(32'h0001_0044, 32'h0BAD_F00D);
    store3(32'h0001_0040, 32'hCAFE_F00D);
    // Abort after 2 cycles: no grant, no write
    hold3(1'b1, 32'h0001_0044, 4'hF, 32'h1234_5678, 2);
    req3 = 1'b0;
    #1;
    check_eq("d3_abort_nogrant", 32'(gnt3), 32'd0);
    @(posedge clk_i); #1;
    // Fresh request needs the full wait again
    load3(32'h0001_0044, 32'h0BAD_F00D);
    load3(32'h0001_0040, 32'hCAFE_F00D);

    // Reset asserted during the response cycle of a load
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0001_0010;
    #1;
    check_eq("rstx_gnt", 32'(gnt0), 32'd1);
    @(posedge clk_i); #1;
    req0 = 1'b0;
    rst_ni = 1'b0;
    #1;
    check_eq("rstx_rvalid", 32'(rvalid0), 32'd0);
    check_eq("rstx_gnt0", 32'(gnt0), 32'd0);
    check_eq("rstx_err", 32'(err0), 32'd0);
    check_eq("rstx_rdata", rdata0, 32'h0);
    @(posedge clk_i); #2;
    check_eq("rstx_rvalid_held", 32'(rvalid0), 32'd0);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #2;
    check_eq("rstx_post_rvalid", 32'(rvalid0), 32'd0);
    load0(32'h0001_0020, 32'hAA22_3344, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qcv_data_ram.md
# qcv_data_ram

Single-ported, word-organised data RAM that terminates the core's data memory bus (req/gnt/rvalid) driven by the load/store unit. It accepts one transaction at a time and applies byte-enabled writes. It returns load data one cycle after grant, flags accesses outside its address window as bus errors, and can insert a programmable grant delay to exercise the LSU's wait-for-grant path.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, ≥ 2.
- BASE_ADDR, 32'h0001_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
- GNT_DELAY, 0, number of cycles data_req_i must be held before data_gnt_o asserts (0 = same-cycle grant).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- data_req_i  in  1  request; held by the master until granted
- data_gnt_o  out  1  grant; combinational
- data_rvalid_o  out  1  load response valid; registered
- data_err_o  out  1  bus error; valid only with store grant or load rvalid
- data_addr_i  in  32  byte address; bits [1:0] ignored
- data_we_i  in  1  1 = store, 0 = load
- data_be_i  in  4  byte enables for stores; ignored for loads
- data_wdata_i  in  32  store data, already lane-aligned
- data_rdata_o  out  32  load data; registered

## Operation
- In range: (data_addr_i − BASE_ADDR) < DEPTH_WORDS*4, using 32-bit unsigned wrap-around subtraction. Word index = offset[log2(DEPTH_WORDS*4)−1:2].
- States: IDLE, WAIT_GNT, RESP.
- IDLE:
  - If data_req_i and GNT_DELAY==0: grant this cycle.
  - If data_req_i and GNT_DELAY>0: load the delay counter with 1 and go to WAIT_GNT.
- WAIT_GNT:
  - If data_req_i is held: increment the counter. Assert gnt when counter == GNT_DELAY.
  - If data_req_i drops before grant: return to IDLE with no side effects. The counter restarts on the next request.
- On grant (any state that grants):
  - Store, in range: write byte lanes where data_be_i[n]=1. data_err_o=0 in the grant cycle. Next state IDLE. be=4'b0000 is a legal no-op.
  - Store, out of range: memory is unchanged. data_err_o=1 in the grant cycle. Next state IDLE.
  - Load: capture the word (in range) or 32'h0, plus err = out-of-range. Next state RESP.
- RESP:
  - data_rvalid_o=1 for exactly one cycle, with data_rdata_o and data_err_o.
  - No grant in this cycle, even if data_req_i=1. Next state IDLE.
- data_err_o is 0 in every cycle other than a store-grant or load-rvalid cycle.
- data_rdata_o holds its last load value until the next load response. It does not change on stores.
- Only one outstanding transaction at a time; no pipelining.
- Memory contents are not reset.

## Timing
- Reset values:
  - data_gnt_o=0, data_rvalid_o=0, data_err_o=0, data_rdata_o=32'h0.
  - State IDLE, counter 0.
- Store latency: write takes effect at the clock edge that ends the grant cycle.
  - Grant occurs GNT_DELAY cycles after the first req cycle (same cycle when 0).
- Load latency: rvalid exactly 1 cycle after the grant cycle.
- Back-to-back: earliest next grant is the cycle after the store grant, or the cycle after rvalid.
- Read of an address written in the immediately preceding grant returns the new data.
- Reset asserted mid-transaction: the pending rvalid is dropped and the FSM goes to IDLE asynchronously. A store completes only if its grant edge occurred before reset.

## Test plan
- GNT_DELAY=0: store 32'hDEAD_BEEF, be=4'hF to 32'h0001_0010. Then load the same address. Required: gnt in the req cycle, err=0; rvalid 1 cycle after the load grant with rdata=32'hDEAD_BEEF.
- Byte-enable merge: word at 0x0001_0020 holds 32'h1122_3344. Store 32'hAA00_0000 with be=4'b1000. Load back and require 32'hAA22_3344.
- Out of range: store to 32'h0000_FFFC requires gnt with err=1 and memory unchanged. Load from BASE_ADDR+DEPTH_WORDS*4 requires rvalid with err=1 and rdata=0.
- GNT_DELAY=3: hold req and require gnt in the 4th req cycle. Repeat, dropping req after 2 cycles: no grant and no write. A fresh req then requires the full 3-cycle wait again.
- Req held through RESP: two loads back to back require grant, rvalid, then grant in the following cycle, never grant and rvalid in the same cycle.
- Assert rst_ni low in the cycle after a load grant: require rvalid never asserts, all outputs go to their reset values, and a new request after reset behaves normally.
